// File: rtl/pwm_duty_capture.sv
// PWM input capture: measures period and high time of an asynchronous PWM pin
// and converts them to a BIT_WIDTH duty value with a serial restoring divider.
module pwm_duty_capture #(
    parameter int BIT_WIDTH = 12,
    parameter int PWM_FREQ  = 1000,
    parameter int SYS_FREQ  = 50000000,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pwm_in,
    output logic [BIT_WIDTH-1:0] duty,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 duty_valid,
    output logic                 stuck,
    output logic                 overrun
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(2 * SYS_FREQ / PWM_FREQ);
    localparam int STEP_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

    localparam logic [0:0] WAIT_RISE = 1'b0;
    localparam logic [0:0] MEAS      = 1'b1;

    logic [2:0]           sync_q;
    logic                 rise;
    logic                 fall;
    logic [0:0]           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] high_q;
    logic [CNT_WIDTH-1:0] period_q;
    logic [CNT_WIDTH:0]   rem;
    logic [CNT_WIDTH:0]   rem_sh;
    logic [CNT_WIDTH:0]   rem_nxt;
    logic [BIT_WIDTH-1:0] quo;
    logic [BIT_WIDTH-1:0] quo_nxt;
    logic [STEP_W-1:0]    step;
    logic                 busy;
    logic                 last_step;
    logic                 ge;

    // sync_q[1] is the synchronized level; sync_q[2] is its one-cycle delay
    assign rise      = sync_q[1] & ~sync_q[2];
    assign fall      = ~sync_q[1] & sync_q[2];
    assign last_step = (step == STEP_W'(BIT_WIDTH - 1));

    always_comb begin
        rem_sh  = rem << 1;
        ge      = (rem_sh >= {1'b0, period_q});
        rem_nxt = ge ? (rem_sh - {1'b0, period_q}) : rem_sh;
        quo_nxt = (quo << 1) | BIT_WIDTH'(ge);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], pwm_in};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_RISE;
            cnt        <= '0;
            high_q     <= '0;
            period_q   <= '0;
            rem        <= '0;
            quo        <= '0;
            step       <= '0;
            busy       <= 1'b0;
            duty       <= '0;
            period     <= '0;
            duty_valid <= 1'b0;
            stuck      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;

            if (rise) begin
                cnt <= CNT_WIDTH'(1);
            end else if (cnt != TIMEOUT_CNT) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end

            if (busy) begin
                rem  <= rem_nxt;
                quo  <= quo_nxt;
                step <= step + STEP_W'(1);
                if (last_step) begin
                    busy       <= 1'b0;
                    duty       <= quo_nxt;
                    period     <= period_q;
                    duty_valid <= 1'b1;
                    stuck      <= 1'b0;
                end
            end

            // Later assignments below deliberately override the divider update:
            // a timeout discards any in-flight result.
            case (state)
                WAIT_RISE: begin
                    if (rise) begin
                        state <= MEAS;
                    end
                end
                MEAS: begin
                    if (fall) begin
                        high_q <= cnt;
                    end
                    if (rise) begin
                        if (!busy) begin
                            period_q <= cnt;
                            rem      <= {1'b0, high_q};
                            quo      <= '0;
                            step     <= '0;
                            busy     <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (cnt == TIMEOUT_CNT) begin
                        state      <= WAIT_RISE;
                        busy       <= 1'b0;
                        duty       <= {BIT_WIDTH{sync_q[1]}};
                        period     <= '0;
                        stuck      <= 1'b1;
                        duty_valid <= 1'b1;
                    end
                end
                default: state <= WAIT_RISE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture: duty conversion, timeout, overrun,
// asynchronous reset mid-division and period changes.
module tb_pwm_duty_capture;

    localparam int BW = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic [BW-1:0] duty;
    logic [CW-1:0] period;
    logic          duty_valid;
    logic          stuck;
    logic          overrun;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc_n = 0;
    int unsigned rise_cyc = 0;
    int unsigned strobes = 0;
    int unsigned s_cyc = 0;
    int unsigned base = 0;
    logic [BW-1:0] s_duty = '0;
    logic [CW-1:0] s_period = '0;
    logic          s_stuck = 1'b0;

    always #5 clk = ~clk;

    pwm_duty_capture #(
        .BIT_WIDTH(BW),
        .PWM_FREQ (10000),
        .SYS_FREQ (1000000),
        .CNT_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .period    (period),
        .duty_valid(duty_valid),
        .stuck     (stuck),
        .overrun   (overrun)
    );

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Capture every strobe so counts expose missing, extra or stretched pulses
    always @(negedge clk) begin
        if (duty_valid) begin
            strobes  <= strobes + 1;
            s_duty   <= duty;
            s_period <= period;
            s_stuck  <= stuck;
            s_cyc    <= cyc_n;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int h, input int p);
        pwm_in   = 1'b1;
        rise_cyc = cyc_n;
        wait_cyc(h);
        pwm_in = 1'b0;
        wait_cyc(p - h);
    endtask

    initial begin
        wait_cyc(3);
        chk("rst_duty", duty, 0);
        chk("rst_period", period, 0);
        chk("rst_valid", duty_valid, 0);
        chk("rst_stuck", stuck, 0);
        chk("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        wait_cyc(5);

        // Basic conversion; each strobe reports the previous pulse's shape
        pulse(25, 100);
        chk("first_rise_no_strobe", strobes, 0);
        pulse(25, 100);
        chk("p25_count", strobes, 1);
        chk("p25_duty", s_duty, 64);
        chk("p25_period", s_period, 100);
        chk("p25_latency", s_cyc, rise_cyc + 11);
        pulse(50, 100);
        chk("p25b_duty", s_duty, 64);
        pulse(1, 100);
        chk("p50_duty", s_duty, 128);
        pulse(99, 100);
        chk("p1_duty", s_duty, 2);
        pulse(25, 100);
        chk("p99_duty", s_duty, 253);
        chk("p99_count", strobes, 5);
        chk("duty_hold", duty, 253);

        // Stuck high, then stuck low, then recovery
        pwm_in = 1'b1;
        wait_cyc(250);
        chk("hi_count", strobes, 7);
        chk("hi_duty", s_duty, 255);
        chk("hi_period", period, 0);
        chk("hi_stuck", stuck, 1);
        pwm_in = 1'b0;
        wait_cyc(50);
        chk("hi_fall_no_strobe", strobes, 7);
        pulse(25, 250);
        chk("lo_count", strobes, 8);
        chk("lo_duty", s_duty, 0);
        chk("lo_stuck", stuck, 1);
        pulse(25, 100);
        chk("rec_first_no_strobe", strobes, 8);
        pulse(25, 100);
        chk("rec_count", strobes, 9);
        chk("rec_duty", s_duty, 64);
        chk("rec_period", s_period, 100);
        chk("rec_stuck", s_stuck, 0);

        // Short periods overrun the divider; accepted samples still convert
        chk("ovr_before", overrun, 0);
        repeat (6) pulse(4, 8);
        chk("ovr_set", overrun, 1);
        chk("ovr_count", strobes, 12);
        chk("ovr_duty", s_duty, 128);
        chk("ovr_period", s_period, 8);
        pulse(25, 100);
        chk("ovr_last_short", s_duty, 128);
        pulse(25, 100);
        chk("ovr_back_duty", s_duty, 64);
        chk("ovr_count2", strobes, 14);
        chk("ovr_sticky", overrun, 1);

        // Asynchronous reset in the middle of a division
        pwm_in = 1'b1;
        wait_cyc(6);
        base = strobes;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_duty", duty, 0);
        chk("mid_rst_period", period, 0);
        chk("mid_rst_valid", duty_valid, 0);
        chk("mid_rst_overrun", overrun, 0);
        pwm_in = 1'b0;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(3);
        pulse(25, 100);
        chk("post_rst_no_strobe", strobes, base);
        pulse(25, 100);
        chk("post_rst_count", strobes, base + 1);
        chk("post_rst_duty", s_duty, 64);
        chk("post_rst_period", s_period, 100);

        // Period step 100 -> 200 with constant high time
        pulse(50, 100);
        chk("step_a_count", strobes, base + 2);
        pulse(50, 200);
        chk("step_b_count", strobes, base + 3);
        chk("step_b_duty", s_duty, 128);
        pulse(50, 200);
        chk("step_c_count", strobes, base + 4);
        chk("step_c_duty", s_duty, 64);
        chk("step_c_period", s_period, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
